// File: rtl/ram_stream_reader_pkg.sv
// Shared types and helpers for the RAM stream reader.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain
    } state_e;

    // Bits needed to index `value` distinct items (0 for value <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// Small synchronous FIFO with flop storage; head word is read straight from the register array.
module stream_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CountWidth = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CountWidth-1:0] count
);

    localparam int unsigned PtrWidth = clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrWidth-1:0]   wr_ptr_q;
    logic [PtrWidth-1:0]   rd_ptr_q;
    logic [CountWidth-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= data_in;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid    = (count_q != '0);
    assign data_out = mem_q[rd_ptr_q];
    assign count    = count_q;

    // The reader's credit check guarantees a full FIFO is never pushed without a pop.
    no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && (count_q == CountWidth'(DEPTH))));

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader: issues credit-limited RAM read strobes, tracks read latency, streams words out.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned LEN_WIDTH  = 12,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  start_len,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_rd_req,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
);

    localparam int unsigned CountWidth    = clog2(FIFO_DEPTH + 1);
    localparam int unsigned InflightWidth = clog2(RD_LATENCY + 1);
    localparam int unsigned SumWidth      = clog2(FIFO_DEPTH + RD_LATENCY + 1);

    state_e                   state_q;
    logic [LEN_WIDTH-1:0]     remaining_q;
    logic [RD_LATENCY-1:0]    inflight_q;
    logic [InflightWidth-1:0] inflight_cnt;
    logic [CountWidth-1:0]    fifo_count;
    logic [SumWidth-1:0]      occupancy;
    logic                     push;
    logic                     pop;
    logic                     last_pop;

    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + InflightWidth'(inflight_q[i]);
        end
    end

    // Pre-pop occupancy: words queued plus reads still travelling through the RAM.
    assign occupancy  = SumWidth'(fifo_count) + SumWidth'(inflight_cnt);
    assign ram_rd_req = (state_q == StRead) && (remaining_q != '0) &&
                        (occupancy < SumWidth'(FIFO_DEPTH));
    assign push       = inflight_q[RD_LATENCY-1];
    assign pop        = out_valid && out_ready;
    assign last_pop   = (state_q == StDrain) && pop && (fifo_count == CountWidth'(1)) &&
                        (inflight_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            inflight_q  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done       <= 1'b0;
            inflight_q <= (inflight_q << 1) | RD_LATENCY'(ram_rd_req);
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (start_len != '0) begin
                            remaining_q <= start_len;
                            state_q     <= StRead;
                            busy        <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    if (ram_rd_req) begin
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == LEN_WIDTH'(1)) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (last_pop) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .CountWidth (CountWidth)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .data_in  (ram_rd_data),
        .pop      (pop),
        .valid    (out_valid),
        .data_out (out_data),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench: two reader instances (latency 1/depth 4 and latency 3/depth 8) on modelled RAMs.
module tb_ram_stream_reader;

    localparam int unsigned DW = 10;
    localparam int unsigned LW = 12;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_drv = 1'b0;
    logic          ready_drv = 1'b1;
    logic          sel = 1'b0;
    logic [LW-1:0] start_len = '0;

    logic          start_a, start_b, ready_a, ready_b;
    logic          busy_a, done_a, req_a, valid_a;
    logic          busy_b, done_b, req_b, valid_b;
    logic [DW-1:0] data_a, data_b, ram_data_a, ram_data_b;

    logic          cur_busy, cur_done, cur_req, cur_valid;
    logic [DW-1:0] cur_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign start_a = start_drv & ~sel;
    assign start_b = start_drv & sel;
    assign ready_a = sel ? 1'b1 : ready_drv;
    assign ready_b = sel ? ready_drv : 1'b1;

    assign cur_busy  = sel ? busy_b  : busy_a;
    assign cur_done  = sel ? done_b  : done_a;
    assign cur_req   = sel ? req_b   : req_a;
    assign cur_valid = sel ? valid_b : valid_a;
    assign cur_data  = sel ? data_b  : data_a;

    ram_stream_reader #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .RD_LATENCY (1),
        .FIFO_DEPTH (4)
    ) dut_a (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start_a),
        .start_len   (start_len),
        .busy        (busy_a),
        .done        (done_a),
        .ram_rd_req  (req_a),
        .ram_rd_data (ram_data_a),
        .out_valid   (valid_a),
        .out_data    (data_a),
        .out_ready   (ready_a)
    );

    ram_stream_reader #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .RD_LATENCY (3),
        .FIFO_DEPTH (8)
    ) dut_b (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start_b),
        .start_len   (start_len),
        .busy        (busy_b),
        .done        (done_b),
        .ram_rd_req  (req_b),
        .ram_rd_data (ram_data_b),
        .out_valid   (valid_b),
        .out_data    (data_b),
        .out_ready   (ready_b)
    );

    // RAM models: word at address k holds k; auto-incrementing read port.
    logic [DW-1:0] addr_a, addr_b;
    logic [DW-1:0] pipe_b [3];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_a     <= '0;
            ram_data_a <= '0;
        end else if (req_a) begin
            addr_a     <= addr_a + 1'b1;
            ram_data_a <= addr_a;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_b    <= '0;
            pipe_b[0] <= '0;
            pipe_b[1] <= '0;
            pipe_b[2] <= '0;
        end else begin
            if (req_b) begin
                addr_b    <= addr_b + 1'b1;
                pipe_b[0] <= addr_b;
            end
            pipe_b[1] <= pipe_b[0];
            pipe_b[2] <= pipe_b[1];
        end
    end
    assign ram_data_b = pipe_b[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // mode 0: ready high; 1: ready toggles (plus an ignored start); 2: ready low 20 cycles.
    task automatic run_burst(input string tag, input logic s, input int len, input int base,
                             input int mode, input bit timing);
        int lat, depth, words, reqs, dones, stall_reqs;
        bit occ_ok;
        lat = s ? 3 : 1;
        depth = s ? 8 : 4;
        words = 0;
        reqs = 0;
        dones = 0;
        stall_reqs = 0;
        occ_ok = 1'b1;
        sel = s;
        @(negedge clk);
        start_drv = 1'b1;
        start_len = LW'(len);
        ready_drv = (mode != 2);
        @(posedge clk);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start_drv = 1'b0;
            case (mode)
                1:       ready_drv = ((c % 2) != 0);
                2:       ready_drv = (c > 20);
                default: ready_drv = 1'b1;
            endcase
            if (mode == 1 && c == 5) begin
                start_drv = 1'b1;
                start_len = LW'(3);
            end
            #1;
            if (cur_req) begin
                if (reqs - words >= depth) occ_ok = 1'b0;
                reqs++;
                if (c <= 20) stall_reqs++;
            end
            if (cur_done) dones++;
            if (timing) begin
                check({tag, "_valid"}, 32'(cur_valid), 32'(c >= lat + 2 && c < lat + 2 + len));
                check({tag, "_done"}, 32'(cur_done), 32'(c == len + lat + 2));
            end
            if (mode == 2 && c == 20) begin
                check({tag, "_hold_valid"}, 32'(cur_valid), 32'd1);
                check({tag, "_hold_data"}, 32'(cur_data), 32'(base));
            end
            if (cur_valid && ready_drv) begin
                check({tag, "_data"}, 32'(cur_data), 32'(base + words));
                words++;
            end
        end
        check({tag, "_words"}, 32'(words), 32'(len));
        check({tag, "_reqs"}, 32'(reqs), 32'(len));
        check({tag, "_dones"}, 32'(dones), 32'd1);
        check({tag, "_credit"}, 32'(occ_ok), 32'd1);
        check({tag, "_busy_end"}, 32'(cur_busy), 32'd0);
        if (mode == 2) check({tag, "_stall_reqs"}, 32'(stall_reqs), 32'(depth));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_req", 32'(req_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_data", 32'(data_a), 32'd0);
        reset_n = 1'b1;

        run_burst("basic", 1'b0, 8, 0, 0, 1'b1);
        run_burst("bp", 1'b0, 16, 8, 1, 1'b0);
        run_burst("stall", 1'b0, 12, 24, 2, 1'b0);

        // Zero-length burst.
        @(negedge clk);
        start_drv = 1'b1;
        start_len = '0;
        @(posedge clk);
        @(negedge clk);
        start_drv = 1'b0;
        #1;
        check("zero_done", 32'(done_a), 32'd1);
        check("zero_busy", 32'(busy_a), 32'd0);
        check("zero_req", 32'(req_a), 32'd0);
        @(negedge clk);
        #1;
        check("zero_done_end", 32'(done_a), 32'd0);

        // Reset during READ with two words queued.
        @(negedge clk);
        start_drv = 1'b1;
        start_len = LW'(10);
        ready_drv = 1'b0;
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            start_drv = 1'b0;
        end
        #1;
        check("pre_rst_valid", 32'(valid_a), 32'd1);
        check("pre_rst_data", 32'(data_a), 32'd36);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_done", 32'(done_a), 32'd0);
        check("mid_rst_req", 32'(req_a), 32'd0);
        check("mid_rst_valid", 32'(valid_a), 32'd0);
        check("mid_rst_data", 32'(data_a), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ready_drv = 1'b1;

        run_burst("post_rst", 1'b0, 4, 0, 0, 1'b1);
        run_burst("lat3", 1'b1, 32, 0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
